// File: rtl/rx_iq_gather_pkg.sv
// rx_iq_gather_pkg
//   Constants and types shared by the rx I/Q gather block and its
//   per-channel slice: default channel count, DDC sample width, audio word
//   width and the word-selector encoding used to step through I, Q, iq3.
package rx_iq_gather_pkg;

  localparam int DEF_V_RX_CHANS = 4;
  localparam int DEF_IQ_W       = 24;  // 16 low bits + 8 high bits per component
  localparam int WORD_W         = 16;
  localparam int TICK_W         = 48;

  typedef enum logic [1:0] {
    WS_I   = 2'd0,
    WS_Q   = 2'd1,
    WS_IQ3 = 2'd2
  } wsel_t;

endpackage

// File: rtl/rx_iq_chan.sv
// rx_iq_chan
//   One receiver channel of the gather block: holding registers that follow
//   the DDC strobe, a captured flag, a shadow bank loaded on set completion
//   and the 3:1 mux presenting the current 16-bit word.
// Ports:
//   adc_clk, reset_n  clock, asynchronous active-low reset
//   ch_en             channel enabled; a disabled channel loads 0 into shadow
//   iq_avail          one-cycle sample strobe for this channel
//   iq_i, iq_q        DDC sample pair
//   complete          set completion from the top level (shadow load, clear)
//   wsel              shared word selector (wsel_t encoding)
//   captured          a sample is held for the set in progress
//   word              current output word from the shadow bank
module rx_iq_chan
  import rx_iq_gather_pkg::*;
#(
  parameter int IQ_W = DEF_IQ_W
) (
  input  logic              adc_clk,
  input  logic              reset_n,
  input  logic              ch_en,
  input  logic              iq_avail,
  input  logic [IQ_W-1:0]   iq_i,
  input  logic [IQ_W-1:0]   iq_q,
  input  logic              complete,
  input  logic [1:0]        wsel,
  output logic              captured,
  output logic [WORD_W-1:0] word
);

  logic [IQ_W-1:0] hold_i, hold_q;
  logic [IQ_W-1:0] sh_i, sh_q;
  logic [IQ_W-1:0] nxt_i, nxt_q;

  // A sample arriving in the completion cycle belongs to the completed set.
  assign nxt_i = iq_avail ? iq_i : hold_i;
  assign nxt_q = iq_avail ? iq_q : hold_q;

  // NOTE: holding and shadow banks are plain flops, not RAM, and have defined
  // reset values, so they sit in the reset branch like any other state.
  always_ff @(posedge adc_clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_i   <= '0;
      hold_q   <= '0;
      sh_i     <= '0;
      sh_q     <= '0;
      captured <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (iq_avail) begin
        hold_i <= iq_i;
        hold_q <= iq_q;
      end
      if (complete) begin
        captured <= 1'b0;
        sh_i     <= ch_en ? nxt_i : '0;
        sh_q     <= ch_en ? nxt_q : '0;
      end else if (iq_avail) begin
        captured <= 1'b1;
      end
    end
  end

  always_comb begin
    // NOTE: default assignment first so no path leaves word unassigned (no latch).
    word = {sh_i[IQ_W-1:WORD_W], sh_q[IQ_W-1:WORD_W]};
    case (wsel_t'(wsel))
      WS_I:    word = sh_i[WORD_W-1:0];
      WS_Q:    word = sh_q[WORD_W-1:0];
      default: ;
    endcase
  end

endmodule

// File: rtl/rx_iq_gather.sv
// rx_iq_gather
//   Gathers one I/Q sample pair per receiver channel from skewed DDC strobes,
//   snapshots the full set plus the ADC tick count into a shadow bank, pulses
//   rx_avail_A and serves I, Q, iq3 words as the audio memory steps.
// Ports:
//   adc_clk, reset_n    clock, asynchronous active-low reset
//   ch_en               channel enable mask
//   iq_avail            per-channel sample strobes
//   iq_i, iq_q          per-channel samples, channel k at [IQ_W*k +: IQ_W]
//   ticks_in            free-running ADC tick counter
//   rd_getI, rd_getQ    word-step requests
//   clr_ovfl            clear overrun status
//   rx_avail_A          one-cycle pulse, shadow bank valid
//   rxn_din_A           per-channel current word, channel k at [16k +: 16]
//   ticks_A             tick value at set completion
//   ovfl_sticky         overrun since last clear
//   ovfl_cnt            saturating overrun count
module rx_iq_gather
  import rx_iq_gather_pkg::*;
#(
  parameter int V_RX_CHANS = DEF_V_RX_CHANS,
  parameter int IQ_W       = DEF_IQ_W
) (
  input  logic                         adc_clk,
  input  logic                         reset_n,
  input  logic [V_RX_CHANS-1:0]        ch_en,
  input  logic [V_RX_CHANS-1:0]        iq_avail,
  input  logic [V_RX_CHANS*IQ_W-1:0]   iq_i,
  input  logic [V_RX_CHANS*IQ_W-1:0]   iq_q,
  input  logic [TICK_W-1:0]            ticks_in,
  input  logic                         rd_getI,
  input  logic                         rd_getQ,
  input  logic                         clr_ovfl,
  output logic                         rx_avail_A,
  output logic [V_RX_CHANS*WORD_W-1:0] rxn_din_A,
  output logic [TICK_W-1:0]            ticks_A,
  output logic                         ovfl_sticky,
  output logic [15:0]                  ovfl_cnt
);

  logic [V_RX_CHANS-1:0] captured;
  logic [V_RX_CHANS-1:0] cap_next;
  logic                  complete;
  logic                  overrun;
  wsel_t                 wsel;

  // Disabled channels count as captured; an all-zero mask never completes.
  assign cap_next = captured | iq_avail;
  assign complete = (&(cap_next | ~ch_en)) && (|ch_en);
  // Any number of channels overrunning together is a single event.
  assign overrun  = |(iq_avail & captured);

  for (genvar k = 0; k < V_RX_CHANS; k++) begin : g_chan
    rx_iq_chan #(.IQ_W(IQ_W)) u_chan (
      .adc_clk  (adc_clk),
      .reset_n  (reset_n),
      .ch_en    (ch_en[k]),
      .iq_avail (iq_avail[k]),
      .iq_i     (iq_i[k*IQ_W +: IQ_W]),
      .iq_q     (iq_q[k*IQ_W +: IQ_W]),
      .complete (complete),
      .wsel     (wsel),
      .captured (captured[k]),
      .word     (rxn_din_A[k*WORD_W +: WORD_W])
    );
  end

  always_ff @(posedge adc_clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_avail_A  <= 1'b0;
      ticks_A     <= '0;
      wsel        <= WS_IQ3;
      ovfl_sticky <= 1'b0;
      ovfl_cnt    <= '0;
    end else begin
      rx_avail_A <= complete;
      if (complete) ticks_A <= ticks_in;

      // I and Q are requested explicitly; iq3 follows Q automatically.
      if (rd_getI)            wsel <= WS_I;
      else if (rd_getQ)       wsel <= WS_Q;
      else if (wsel == WS_Q)  wsel <= WS_IQ3;

      // An overrun in the clear cycle wins and restarts the count at 1.
      if (overrun) begin
        ovfl_sticky <= 1'b1;
        if (clr_ovfl)               ovfl_cnt <= 16'd1;
        else if (ovfl_cnt != '1)    ovfl_cnt <= ovfl_cnt + 16'd1;
      end else if (clr_ovfl) begin
        ovfl_sticky <= 1'b0;
        ovfl_cnt    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rx_iq_gather.sv
// tb_rx_iq_gather
//   Self-checking bench: a set-level model of the gather block is stepped
//   once per clock and compared against the outputs on every falling edge;
//   directed scenarios add literal expectations.
module tb_rx_iq_gather;

  localparam int N = 4;

  logic            adc_clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    ch_en;
  logic [N-1:0]    iq_avail;
  logic [N*24-1:0] iq_i;
  logic [N*24-1:0] iq_q;
  logic [47:0]     ticks_in;
  logic            rd_getI;
  logic            rd_getQ;
  logic            clr_ovfl;
  logic            rx_avail_A;
  logic [N*16-1:0] rxn_din_A;
  logic [47:0]     ticks_A;
  logic            ovfl_sticky;
  logic [15:0]     ovfl_cnt;

  rx_iq_gather #(.V_RX_CHANS(N), .IQ_W(24)) dut (
    .adc_clk     (adc_clk),
    .reset_n     (reset_n),
    .ch_en       (ch_en),
    .iq_avail    (iq_avail),
    .iq_i        (iq_i),
    .iq_q        (iq_q),
    .ticks_in    (ticks_in),
    .rd_getI     (rd_getI),
    .rd_getQ     (rd_getQ),
    .clr_ovfl    (clr_ovfl),
    .rx_avail_A  (rx_avail_A),
    .rxn_din_A   (rxn_din_A),
    .ticks_A     (ticks_A),
    .ovfl_sticky (ovfl_sticky),
    .ovfl_cnt    (ovfl_cnt)
  );

  always #5 adc_clk = ~adc_clk;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [23:0] m_hold_i [N];
  logic [23:0] m_hold_q [N];
  logic [23:0] m_sh_i   [N];
  logic [23:0] m_sh_q   [N];
  bit          m_cap    [N];
  bit          m_avail;
  logic [47:0] m_ticks;
  bit          m_sticky;
  int          m_cnt;
  int          m_wpos;   // 0 = I, 1 = Q, 2 = iq3

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_hold_i[k] = '0; m_hold_q[k] = '0;
      m_sh_i[k]   = '0; m_sh_q[k]   = '0;
      m_cap[k]    = 1'b0;
    end
    m_avail = 1'b0; m_ticks = '0; m_sticky = 1'b0; m_cnt = 0; m_wpos = 2;
  endtask

  task automatic model_update();
    bit ovr;
    bit all_in;
    bit any_en;
    bit cap_n [N];
    ovr = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (iq_avail[k] && m_cap[k]) ovr = 1'b1;
      if (iq_avail[k]) begin
        m_hold_i[k] = iq_i[k*24 +: 24];
        m_hold_q[k] = iq_q[k*24 +: 24];
      end
      cap_n[k] = m_cap[k] || iq_avail[k];
    end
    all_in = 1'b1; any_en = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (ch_en[k]) begin
        any_en = 1'b1;
        if (!cap_n[k]) all_in = 1'b0;
      end
    end
    m_avail = all_in && any_en;
    for (int k = 0; k < N; k++) begin
      if (m_avail) begin
        m_sh_i[k] = ch_en[k] ? m_hold_i[k] : 24'd0;
        m_sh_q[k] = ch_en[k] ? m_hold_q[k] : 24'd0;
        m_cap[k]  = 1'b0;
      end else begin
        m_cap[k]  = cap_n[k];
      end
    end
    if (m_avail) m_ticks = ticks_in;
    if (ovr) begin
      m_sticky = 1'b1;
      m_cnt    = clr_ovfl ? 1 : ((m_cnt < 65535) ? m_cnt + 1 : 65535);
    end else if (clr_ovfl) begin
      m_sticky = 1'b0;
      m_cnt    = 0;
    end
    if (rd_getI)           m_wpos = 0;
    else if (rd_getQ)      m_wpos = 1;
    else if (m_wpos == 1)  m_wpos = 2;
  endtask

  function automatic logic [N*16-1:0] exp_din();
    logic [N*16-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++) begin
      case (m_wpos)
        0:       r[k*16 +: 16] = m_sh_i[k][15:0];
        1:       r[k*16 +: 16] = m_sh_q[k][15:0];
        default: r[k*16 +: 16] = {m_sh_i[k][23:16], m_sh_q[k][23:16]};
      endcase
    end
    return r;
  endfunction

  // Single compare process, away from the active edge.
  always @(negedge adc_clk) begin
    if (cmp_en && reset_n) begin
      check("rx_avail_A",  {63'd0, rx_avail_A},  {63'd0, m_avail});
      check("rxn_din_A",   64'(rxn_din_A),       64'(exp_din()));
      check("ticks_A",     {16'd0, ticks_A},     {16'd0, m_ticks});
      check("ovfl_sticky", {63'd0, ovfl_sticky}, {63'd0, m_sticky});
      check("ovfl_cnt",    {48'd0, ovfl_cnt},    64'(m_cnt));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge adc_clk);
    if (reset_n) model_update();
    #2;
  endtask

  task automatic set_ch(input int k, input logic [23:0] i, input logic [23:0] q);
    iq_i[k*24 +: 24] = i;
    iq_q[k*24 +: 24] = q;
  endtask

  task automatic rand_samples();
    for (int k = 0; k < N; k++) set_ch(k, 24'($urandom), 24'($urandom));
  endtask

  int pulses;
  int pulse_t;
  logic [23:0] saved_i;
  logic [23:0] val_b;

  initial begin
    reset_n = 1'b0; ch_en = '1; iq_avail = '0; iq_i = '0; iq_q = '0;
    ticks_in = '0; rd_getI = 1'b0; rd_getQ = 1'b0; clr_ovfl = 1'b0;
    model_reset();
    repeat (3) step();
    check("reset rx_avail_A",  {63'd0, rx_avail_A},  64'd0);
    check("reset rxn_din_A",   64'(rxn_din_A),       64'd0);
    check("reset ticks_A",     {16'd0, ticks_A},     64'd0);
    check("reset ovfl_sticky", {63'd0, ovfl_sticky}, 64'd0);
    check("reset ovfl_cnt",    {48'd0, ovfl_cnt},    64'd0);
    reset_n = 1'b1;
    cmp_en  = 1'b1;
    repeat (2) step();

    // ---- aligned strobes ----
    rand_samples();
    set_ch(0, 24'hABCDEF, 24'h123456);
    iq_avail = 4'hF; ticks_in = 48'h1000;
    step();
    iq_avail = '0; ticks_in = 48'h7777;
    check("aligned avail high", {63'd0, rx_avail_A}, 64'd1);
    check("aligned ticks_A",    {16'd0, ticks_A},    64'h1000);
    step();
    check("aligned avail one cycle", {63'd0, rx_avail_A}, 64'd0);
    repeat (3) step();
    rd_getI = 1'b1; step();
    rd_getI = 1'b0; rd_getQ = 1'b1;
    check("aligned ch0 I", 64'(rxn_din_A[15:0]), 64'hCDEF);
    step();
    rd_getQ = 1'b0;
    check("aligned ch0 Q", 64'(rxn_din_A[15:0]), 64'h3456);
    step();
    check("aligned ch0 iq3", 64'(rxn_din_A[15:0]), 64'hAB12);
    repeat (3) step();
    check("aligned ch0 iq3 held", 64'(rxn_din_A[15:0]), 64'hAB12);

    // ---- skewed strobes: 0, 4, 35, 36 relative ----
    pulses = 0; pulse_t = -1;
    for (int t = 0; t <= 40; t++) begin
      rand_samples();
      iq_avail = '0;
      if (t == 0)  iq_avail[0] = 1'b1;
      if (t == 4)  iq_avail[1] = 1'b1;
      if (t == 35) iq_avail[2] = 1'b1;
      if (t == 36) begin iq_avail[3] = 1'b1; saved_i = iq_i[3*24 +: 24]; end
      step();
      if (rx_avail_A) begin pulses++; pulse_t = t; end
    end
    iq_avail = '0;
    check("skew pulse count", 64'(pulses), 64'd1);
    check("skew pulse cycle", 64'(pulse_t), 64'd36);
    rd_getI = 1'b1; step(); rd_getI = 1'b0;
    check("skew ch3 I", 64'(rxn_din_A[63:48]), {48'd0, saved_i[15:0]});

    // ---- disabled channel ----
    ch_en = 4'b1011; pulses = 0;
    rand_samples(); iq_avail = 4'b0001; step();
    if (rx_avail_A) pulses++;
    rand_samples(); iq_avail = 4'b1010; step();
    if (rx_avail_A) pulses++;
    iq_avail = '0; step();
    if (rx_avail_A) pulses++;
    check("disabled pulse count", 64'(pulses), 64'd1);
    rd_getI = 1'b1; step(); rd_getI = 1'b0; rd_getQ = 1'b1;
    check("disabled ch2 I", 64'(rxn_din_A[47:32]), 64'd0);
    step(); rd_getQ = 1'b0;
    check("disabled ch2 Q", 64'(rxn_din_A[47:32]), 64'd0);
    step();
    check("disabled ch2 iq3", 64'(rxn_din_A[47:32]), 64'd0);

    // ---- overrun ----
    ch_en = 4'hF; clr_ovfl = 1'b1; step(); clr_ovfl = 1'b0;
    rand_samples(); iq_avail = 4'b0111; step();
    rand_samples(); val_b = iq_i[1*24 +: 24]; iq_avail = 4'b0010; step();
    rand_samples(); iq_avail = 4'b1000; step();
    iq_avail = '0;
    check("overrun avail",  {63'd0, rx_avail_A},  64'd1);
    check("overrun sticky", {63'd0, ovfl_sticky}, 64'd1);
    check("overrun cnt",    {48'd0, ovfl_cnt},    64'd1);
    rd_getI = 1'b1; step(); rd_getI = 1'b0;
    check("overrun ch1 is B", 64'(rxn_din_A[31:16]), {48'd0, val_b[15:0]});
    rand_samples(); iq_avail = 4'b0001; step();
    rand_samples(); iq_avail = 4'b0001; clr_ovfl = 1'b1; step();
    iq_avail = '0; clr_ovfl = 1'b0;
    check("clr+overrun cnt",    {48'd0, ovfl_cnt},    64'd1);
    check("clr+overrun sticky", {63'd0, ovfl_sticky}, 64'd1);
    rand_samples(); iq_avail = 4'b1110; step(); iq_avail = '0; step();

    // ---- reset mid-set ----
    rand_samples(); iq_avail = 4'b0011; step();
    iq_avail = '0; reset_n = 1'b0; model_reset(); step();
    reset_n = 1'b1;
    pulses = 0;
    rand_samples(); iq_avail = 4'b1100; step();
    if (rx_avail_A) pulses++;
    iq_avail = '0;
    repeat (4) begin step(); if (rx_avail_A) pulses++; end
    check("reset mid-set no pulse", 64'(pulses), 64'd0);
    rand_samples(); iq_avail = 4'b0011; step();
    if (rx_avail_A) pulses++;
    iq_avail = '0;
    repeat (4) begin step(); if (rx_avail_A) pulses++; end
    check("reset mid-set full set one pulse", 64'(pulses), 64'd1);

    // ---- randomized traffic ----
    for (int t = 0; t < 3000; t++) begin
      if ($urandom_range(0, 99) == 0) ch_en = 4'($urandom_range(0, 15));
      else if ($urandom_range(0, 199) == 0) ch_en = 4'hF;
      rand_samples();
      for (int k = 0; k < N; k++) iq_avail[k] = ($urandom_range(0, 5) == 0);
      rd_getI  = ($urandom_range(0, 7) == 0);
      rd_getQ  = ($urandom_range(0, 3) == 0);
      clr_ovfl = ($urandom_range(0, 49) == 0);
      ticks_in = {16'($urandom), 32'($urandom)};
      step();
    end
    iq_avail = '0; rd_getI = 1'b0; rd_getQ = 1'b0; clr_ovfl = 1'b0;

    // ---- saturation ----
    reset_n = 1'b0; model_reset(); step(); reset_n = 1'b1;
    ch_en = 4'b0011; iq_avail = 4'b0001;
    for (int t = 0; t < 65541; t++) step();
    iq_avail = '0;
    check("saturation cnt",    {48'd0, ovfl_cnt},    64'hFFFF);
    check("saturation sticky", {63'd0, ovfl_sticky}, 64'd1);
    step();

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
